// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues decoded RV32I ALU ops, waits for the ALU to settle,
// and returns the registered result, branch decision and illegal flag.
module alu_issue_ctrl #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  aluop,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_branch,
    output logic        out_taken,
    output logic        out_illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             br_zero;
    logic             br_inv;
    logic             accept;

    logic [3:0]  d_op;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic [4:0]  d_rd;
    logic        d_br;
    logic        d_ill;
    logic        d_zero;
    logic        d_inv;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    function automatic logic [3:0] f3_op(input logic [2:0] f);
        case (f)
            3'b000:  f3_op = OP_ADD;
            3'b001:  f3_op = OP_SLL;
            3'b010:  f3_op = OP_SLT;
            3'b011:  f3_op = OP_SLTU;
            3'b100:  f3_op = OP_XOR;
            3'b101:  f3_op = OP_SRL;
            3'b110:  f3_op = OP_OR;
            default: f3_op = OP_AND;
        endcase
    endfunction

    // Decode the incoming instruction into ALU controls and branch info
    always_comb begin
        d_op   = OP_ADD;
        d_a    = 32'd0;
        d_b    = 32'd0;
        d_rd   = instr[11:7];
        d_br   = 1'b0;
        d_ill  = 1'b0;
        d_zero = 1'b0;
        d_inv  = 1'b0;
        case (opc)
            7'b0110011: begin
                d_a  = rs1_data;
                d_b  = rs2_data;
                d_op = f3_op(f3);
                if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d_op = OP_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d_op = OP_SRA;
                end else if (f7 != 7'b0000000) begin
                    d_ill = 1'b1;
                end
            end
            7'b0010011: begin
                d_a  = rs1_data;
                d_b  = {{20{instr[31]}}, instr[31:20]};
                d_op = f3_op(f3);
                if (f3 == 3'b001 && f7 != 7'b0000000) begin
                    d_ill = 1'b1;
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'b0100000) d_op = OP_SRA;
                    else if (f7 != 7'b0000000) d_ill = 1'b1;
                end
            end
            7'b0110111: begin
                d_b = {instr[31:12], 12'b0};
            end
            7'b0010111: begin
                d_a = pc;
                d_b = {instr[31:12], 12'b0};
            end
            7'b1100011: begin
                d_a   = rs1_data;
                d_b   = rs2_data;
                d_rd  = 5'd0;
                d_br  = 1'b1;
                d_inv = f3[0];
                case (f3[2:1])
                    2'b00: begin
                        d_op   = OP_SUB;
                        d_zero = 1'b1;
                    end
                    2'b10:   d_op = OP_SLT;
                    2'b11:   d_op = OP_SLTU;
                    default: d_ill = 1'b1;
                endcase
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) d_br = 1'b0;
    end

    assign in_ready  = (state == S_IDLE) ||
                       (state == S_DONE && out_ready);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;

    // Issue, settle-count and result-capture state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            aluop       <= 4'd0;
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            out_result  <= 32'd0;
            out_rd      <= 5'd0;
            out_branch  <= 1'b0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
            br_zero     <= 1'b0;
            br_inv      <= 1'b0;
        end else if (accept) begin
            aluop       <= d_op;
            alu_a       <= d_a;
            alu_b       <= d_b;
            out_rd      <= d_rd;
            out_branch  <= d_br;
            out_illegal <= d_ill;
            out_result  <= 32'd0;
            out_taken   <= 1'b0;
            br_zero     <= d_zero;
            br_inv      <= d_inv;
            cnt         <= '0;
            state       <= d_ill ? S_DONE : S_EXEC;
        end else begin
            case (state)
                S_EXEC: begin
                    if (cnt == CNT_LAST) begin
                        out_result <= alu_result;
                        out_taken  <= out_branch &&
                            ((br_zero ? alu_zero : alu_result[0]) ^ br_inv);
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                S_IDLE: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issuing side of the RV32I ALU interface: accepts a decoded-stage instruction with operands, generates the 4-bit ALU op code and A/B operands, and waits a programmable settle time.
- Captures the ALU result and zero flag, then returns a registered result, a branch decision and an illegal flag.
- Sits between the register-read stage and writeback/branch resolution, in front of the combinational ALU.
- Upstream and downstream both use valid/ready handshakes.

Parameters:
- EXEC_CYCLES, 1, number of cycles the ALU inputs are held stable before the result is sampled (>=1; covers ALU propagation delay).
- CNT_W, 4, width of the settle counter; must hold EXEC_CYCLES-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction/operands valid.
- in_ready  out  1  block can accept.
- instr  in  32  RV32I instruction word.
- pc  in  32  instruction address.
- rs1_data  in  32  rs1 value.
- rs2_data  in  32  rs2 value.
- alu_a  out  32  ALU operand A (registered).
- alu_b  out  32  ALU operand B (registered).
- aluop  out  4  ALU op code (registered).
- alu_result  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_result  out  32  captured result.
- out_rd  out  5  destination register (instr[11:7]).
- out_branch  out  1  instruction was a branch.
- out_taken  out  1  branch condition true.
- out_illegal  out  1  unsupported encoding.

Behaviour:
- Reset: state IDLE, counter 0. All outputs 0 except in_ready=1 (in_ready is a state decode).
- Reset is asynchronous and takes effect mid-operation; any in-flight instruction is discarded.
- States:
  - IDLE: in_ready=1. On in_valid, register aluop/alu_a/alu_b/rd/branch info and clear the counter. Go to EXEC, or to DONE if illegal.
  - EXEC: in_ready=0. Counter increments each cycle. At the edge where counter==EXEC_CYCLES-1, latch alu_result into out_result and evaluate out_taken; go to DONE.
  - DONE: out_valid=1, all out_* held stable. On out_ready:
    - if in_valid is also high, accept the new instruction in the same edge and go to EXEC (or DONE if illegal);
    - else go to IDLE.
  - in_ready = IDLE or (DONE and out_ready).
- Latency: out_valid rises EXEC_CYCLES edges after the accept edge; an illegal op gives out_valid on the next edge.
- aluop, alu_a and alu_b are stable from the accept edge until the next accept.
- Decode, by opcode:
  - 0110011 (R): funct3 gives 000 add/sub (funct7[5]), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra (funct7[5]), 110 or, 111 and. aluop codes are 0000 add, 0001 sub, 0101 sll, 1000 slt, 1001 sltu, 0010 xor, 0110 srl, 0111 sra, 0011 or, 0100 and. A=rs1, B=rs2. funct7 other than 0000000, or 0100000 on funct3 000/101, is illegal.
  - 0010011 (I): same mapping, except funct3 000 is always add. B=sign-extended instr[31:20]. For funct3 001, funct7 must be 0000000. For funct3 101, funct7 0100000 selects sra and 0000000 selects srl; anything else is illegal.
  - 0110111 (LUI): A=0, B={instr[31:12],12'b0}, add.
  - 0010111 (AUIPC): A=pc, B=U-immediate, add.
  - 1100011 (branch): A=rs1, B=rs2, out_branch=1, out_rd=0.
    - beq/bne use sub; taken = alu_zero / !alu_zero.
    - blt/bge use slt; bltu/bgeu use sltu; taken = alu_result[0] / !alu_result[0].
    - funct3 010/011 is illegal.
  - Any other opcode is illegal.
- Illegal instruction: out_illegal=1, out_result=0, out_taken=0, out_branch=0; the ALU is not waited on.
- out_taken=0 for every non-branch op.
- in_valid while in EXEC is ignored; upstream must hold it.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC -> next cycle in_ready=1, out_valid=0, aluop=0, alu_a=0, alu_b=0.
- ADD, EXEC_CYCLES=1: instr 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 -> aluop=0000, A=5, B=7; with ALU model, out_valid one edge after accept, out_result=12, out_rd=3.
- SRAI: instr 0x4030D093 (srai x1,x1,3), rs1=0x80000000 -> aluop=0111, B[4:0]=3, out_result=0xF0000000. Also instr 0x2030D093 -> out_illegal=1 on the next edge.
- Branches: bne with rs1=rs2=9 -> aluop=0001, out_branch=1, out_taken=0. bltu with rs1=1, rs2=0xFFFFFFFF -> aluop=1001, out_taken=1.
- Backpressure, EXEC_CYCLES=3: out_ready held low 4 cycles -> out_valid and out_result stable, in_ready=0. Release with in_valid=1 -> back-to-back accept in the same edge, and the next out_valid 3 edges later.
- AUIPC: pc=0x1000, instr 0x00012217 -> A=0x1000, B=0x12000, out_result=0x13000. An opcode-0x0F instruction -> out_illegal=1, out_result=0.
